// File: rtl/ifu_fetch_queue_if.sv
// Fetch-side bus bundle for ifu_fetch_queue.
// Carries the instruction SRAM request/response channel and the IF->ID handshake.
//   master : the fetch unit (drives inst_sram_* requests, if_to_id_valid/zip)
//   slave  : memory + decode stage (drive addr_ok/data_ok/rdata, id_allowin/br_stall)
interface ifu_fetch_queue_if #(
  parameter int unsigned IF2ID_LEN = 81
) ();
  logic                 inst_sram_req;
  logic                 inst_sram_wr;
  logic [1:0]           inst_sram_size;
  logic [3:0]           inst_sram_wstrb;
  logic [31:0]          inst_sram_wdata;
  logic [31:0]          inst_sram_addr;
  logic                 inst_sram_addr_ok;
  logic                 inst_sram_data_ok;
  logic [31:0]          inst_sram_rdata;
  logic                 id_allowin;
  logic                 br_stall;
  logic                 if_to_id_valid;
  logic [IF2ID_LEN-1:0] if_to_id_zip;

  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata,
    output inst_sram_addr, if_to_id_valid, if_to_id_zip,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, id_allowin, br_stall
  );

  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata,
    input  inst_sram_addr, if_to_id_valid, if_to_id_zip,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, id_allowin, br_stall
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch unit with pipelined SRAM requests and a fetched-instruction queue.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   redirect_valid/_target : flush + new fetch PC (merged WB flush / ID branch)
//   fetch_vaddr         : current fetch PC to the external translator
//   fetch_paddr         : translated address (same cycle), forwarded as inst_sram_addr
//   fetch_ex_valid/_ecode : translator fault for fetch_vaddr
//   bus (master)        : inst_sram request/response channel and IF->ID handshake;
//                         if_to_id_zip = {inst, pc, ex_valid, ecode, esubcode=0, is_ertn=0}
module ifu_fetch_queue #(
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h1c00_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  output logic [31:0]       fetch_vaddr,
  input  logic [31:0]       fetch_paddr,
  input  logic              fetch_ex_valid,
  input  logic [5:0]        fetch_ex_ecode,
  ifu_fetch_queue_if.master bus
);

  localparam int unsigned QAW      = $clog2(QUEUE_DEPTH);
  localparam logic [5:0]  EcodeAde = 6'h08;
  localparam logic [31:0] NopInst  = 32'h0280_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        ex;
    logic [5:0]  ecode;
  } entry_t;

  logic [31:0] pc_q, pc_d;
  logic [2:0]  outst_q, outst_d;
  logic [2:0]  discard_q, discard_d;
  logic        stopped_q, stopped_d;
  logic [QAW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  entry_t      queue_q [QUEUE_DEPTH];
  logic [31:0] infl_q [MAX_OUTSTANDING];
  logic [31:0] infl_d [MAX_OUTSTANDING];

  logic [2:0]   live;
  logic [QAW:0] count;
  logic         misaligned, fault;
  logic [5:0]   fault_ecode;
  logic         req, acc, dok, resp, drop, fault_push, push, pop, id_valid;
  logic [2:0]   push_idx;
  entry_t       push_entry, head;

  // Requests whose responses will still be kept (the rest are pre-redirect leftovers).
  assign live  = outst_q - discard_q;
  assign count = wr_ptr_q - rd_ptr_q;

  assign misaligned  = (pc_q[1:0] != 2'b00);
  assign fault       = misaligned | fetch_ex_valid;
  assign fault_ecode = misaligned ? EcodeAde : fetch_ex_ecode;

  // Slots already promised to live requests are reserved, so the queue cannot overflow.
  assign req = !stopped_q && !redirect_valid && !fault &&
               (32'(outst_q) < MAX_OUTSTANDING) &&
               ((32'(live) + 32'(count)) < QUEUE_DEPTH);
  assign acc = req & bus.inst_sram_addr_ok;

  assign dok  = bus.inst_sram_data_ok & (outst_q != 3'd0);
  assign resp = dok & (discard_q == 3'd0) & !redirect_valid;
  assign drop = dok & (discard_q != 3'd0);

  // Fault marker waits for all older live responses so entries stay in PC order.
  assign fault_push = fault && !stopped_q && !redirect_valid && (live == 3'd0) &&
                      (32'(count) < QUEUE_DEPTH);
  assign push = resp | fault_push;

  assign id_valid = (count != '0) && !redirect_valid;
  assign pop      = id_valid & bus.id_allowin & !bus.br_stall;

  assign push_idx = live - {2'b00, resp};
  assign head     = queue_q[rd_ptr_q[QAW-1:0]];

  always_comb begin
    push_entry = '{inst: NopInst, pc: pc_q, ex: 1'b1, ecode: fault_ecode};
    if (resp) begin
      push_entry = '{inst: bus.inst_sram_rdata, pc: infl_q[0], ex: 1'b0, ecode: 6'd0};
    end
  end

  // In-flight PCs kept as a shift register: index 0 is the oldest live request.
  always_comb begin
    infl_d = infl_q;
    if (resp) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING) - 1; i++) begin
        infl_d[i] = infl_q[i+1];
      end
    end
    if (acc) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        if (i == int'(push_idx)) begin
          infl_d[i] = pc_q;
        end
      end
    end
  end

  always_comb begin
    pc_d      = pc_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    stopped_d = stopped_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (redirect_valid) begin
      pc_d      = redirect_target;
      stopped_d = 1'b0;
      outst_d   = outst_q - {2'b00, dok};
      discard_d = outst_q - {2'b00, dok};
      wr_ptr_d  = rd_ptr_q;
    end else begin
      outst_d = outst_q + {2'b00, acc} - {2'b00, dok};
      if (drop) begin
        discard_d = discard_q - 3'd1;
      end
      if (acc) begin
        pc_d = pc_q + 32'd4;
      end
      if (fault_push) begin
        stopped_d = 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + {{QAW{1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + {{QAW{1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      outst_q   <= 3'd0;
      discard_q <= 3'd0;
      stopped_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      stopped_q <= stopped_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Storage needs no reset: validity is tracked by the pointers and counters above.
  always_ff @(posedge clk) begin
    infl_q <= infl_d;
    if (push && !reset) begin
      queue_q[wr_ptr_q[QAW-1:0]] <= push_entry;
    end
  end

  assign fetch_vaddr         = pc_q;
  assign bus.inst_sram_req   = req;
  assign bus.inst_sram_wr    = 1'b0;
  assign bus.inst_sram_size  = 2'b10;
  assign bus.inst_sram_wstrb = 4'b0000;
  assign bus.inst_sram_wdata = 32'd0;
  assign bus.inst_sram_addr  = fetch_paddr;
  assign bus.if_to_id_valid  = id_valid;
  assign bus.if_to_id_zip    = {head.inst, head.pc, head.ex, head.ecode, 9'd0, 1'b0};

endmodule

// File: tb/tb_ifu_fetch_queue.sv
module tb_ifu_fetch_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h1c00_0000;
  localparam logic [5:0]  ADE   = 6'h08;
  localparam logic [5:0]  TLBR  = 6'h3f;
  localparam logic [31:0] NOP   = 32'h0280_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] fetch_vaddr, fetch_paddr;
  logic        fetch_ex_valid;
  logic [5:0]  fetch_ex_ecode;

  ifu_fetch_queue_if bus ();

  ifu_fetch_queue #(
    .QUEUE_DEPTH    (DEPTH),
    .MAX_OUTSTANDING(MAXO),
    .RESET_PC       (RPC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .fetch_vaddr    (fetch_vaddr),
    .fetch_paddr    (fetch_paddr),
    .fetch_ex_valid (fetch_ex_valid),
    .fetch_ex_ecode (fetch_ex_ecode),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // Toy translator: fixed XOR mapping.
  assign fetch_paddr = fetch_vaddr ^ 32'h8000_0000;

  function automatic logic [31:0] inst_of(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic [80:0] mk_zip(logic [31:0] inst, logic [31:0] pc, logic ex,
                                         logic [5:0] ec);
    return {inst, pc, ex, ec, 9'd0, 1'b0};
  endfunction

  // Reference model: list of outstanding requests (stale ones killed by redirect) and
  // list of queued entries.
  typedef struct { logic [31:0] pc; bit stale; } ofl_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc; bit ex; logic [5:0] ec; } ent_t;
  ofl_t        m_out[$];
  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_stop;
  logic [31:0] mem[$];   // memory side: physical addresses awaiting a response
  int          ao_mode, do_mode;
  int          n_vec, n_err;

  task automatic chk(string nm, logic [80:0] act, logic [80:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_ready(bit r);
    bus.id_allowin = r;
    bus.br_stall   = 1'b0;
  endtask

  task automatic tick();
    int          live;
    bit          fault, exp_req, exp_val, dok, dk, acc, fpush;
    logic [5:0]  ec;
    logic [31:0] pa;
    ent_t        e;
    ofl_t        o;
    bus.inst_sram_addr_ok = (ao_mode == 1) || (ao_mode == 2 && $urandom_range(0, 1) == 1);
    dk = (mem.size() > 0) && (do_mode == 1 || (do_mode == 2 && $urandom_range(0, 2) != 0));
    bus.inst_sram_data_ok = dk;
    if (dk) bus.inst_sram_rdata = inst_of(mem[0]);
    else    bus.inst_sram_rdata = $urandom;
    #1;
    if (reset) begin
      m_out.delete();
      m_q.delete();
      m_pc   = RPC;
      m_stop = 0;
    end else begin
      live = 0;
      foreach (m_out[i]) if (!m_out[i].stale) live++;
      fault   = (m_pc[1:0] != 2'b00) || fetch_ex_valid;
      ec      = (m_pc[1:0] != 2'b00) ? ADE : fetch_ex_ecode;
      exp_req = !m_stop && !redirect_valid && !fault && m_out.size() < MAXO &&
                (live + m_q.size()) < DEPTH;
      exp_val = (m_q.size() > 0) && !redirect_valid;
      chk("fetch_vaddr", fetch_vaddr, m_pc);
      chk("inst_sram_req", bus.inst_sram_req, exp_req);
      chk("inst_sram_addr", bus.inst_sram_addr, fetch_paddr);
      chk("if_to_id_valid", bus.if_to_id_valid, exp_val);
      if (exp_val) chk("if_to_id_zip", bus.if_to_id_zip,
                       mk_zip(m_q[0].inst, m_q[0].pc, m_q[0].ex, m_q[0].ec));
      dok   = dk && m_out.size() > 0;
      fpush = fault && !m_stop && live == 0 && m_q.size() < DEPTH;
      if (redirect_valid) begin
        if (dok) o = m_out.pop_front();
        foreach (m_out[i]) m_out[i].stale = 1;
        m_q.delete();
        m_pc   = redirect_target;
        m_stop = 0;
      end else begin
        if (exp_val && bus.id_allowin && !bus.br_stall) e = m_q.pop_front();
        if (dok) begin
          o = m_out.pop_front();
          if (!o.stale)
            m_q.push_back('{inst: bus.inst_sram_rdata, pc: o.pc, ex: 0, ec: 6'd0});
        end
        if (exp_req && bus.inst_sram_addr_ok) begin
          m_out.push_back('{pc: m_pc, stale: 0});
          m_pc = m_pc + 32'd4;
        end else if (fpush) begin
          m_q.push_back('{inst: NOP, pc: m_pc, ex: 1, ec: ec});
          m_stop = 1;
        end
      end
    end
    acc = bus.inst_sram_req && bus.inst_sram_addr_ok;
    pa  = fetch_paddr;
    @(posedge clk);
    if (dk) pa = pa;
    if (dk) mem.pop_front();
    if (acc) mem.push_back(pa);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    ao_mode        = 0;
    do_mode        = 0;
    redirect_valid = 1'b0;
    fetch_ex_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [31:0] target;
    bit          exv;
    logic [5:0]  ec;
    bit          e_req;
    bit          e_val;
    logic [5:0]  e_ec;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl[7];
    int          held, got;
    bit          found;
    logic [80:0] zips[2];
    logic [31:0] t;

    tbl[0] = '{32'h1c00_1000, 0, 6'h00, 1, 0, 6'h00};
    tbl[1] = '{32'h1c00_0002, 0, 6'h00, 0, 1, ADE};
    tbl[2] = '{32'h1c00_0001, 0, 6'h00, 0, 1, ADE};
    tbl[3] = '{32'h1c00_0003, 1, TLBR,  0, 1, ADE};
    tbl[4] = '{32'h1c00_2000, 1, TLBR,  0, 1, TLBR};
    tbl[5] = '{32'h1c00_3000, 1, 6'h03, 0, 1, 6'h03};
    tbl[6] = '{32'hffff_fffc, 0, 6'h00, 1, 0, 6'h00};

    n_vec           = 0;
    n_err           = 0;
    redirect_target = 32'd0;
    fetch_ex_ecode  = 6'd0;
    set_ready(0);
    do_reset();

    // Reset state
    chk("rst_vaddr", fetch_vaddr, RPC);
    chk("rst_req", bus.inst_sram_req, 1'b1);
    chk("rst_valid", bus.if_to_id_valid, 1'b0);
    chk("const_wr", bus.inst_sram_wr, 1'b0);
    chk("const_size", bus.inst_sram_size, 2'b10);
    chk("const_wstrb", bus.inst_sram_wstrb, 4'h0);
    chk("const_wdata", bus.inst_sram_wdata, 32'h0);

    // Redirect vectors: target, translator fault, expected request / fault entry
    foreach (tbl[i]) begin
      redirect_valid  = 1'b1;
      redirect_target = tbl[i].target;
      fetch_ex_valid  = 1'b0;
      tick();
      redirect_valid = 1'b0;
      fetch_ex_valid = tbl[i].exv;
      fetch_ex_ecode = tbl[i].ec;
      #1;
      chk("tbl_vaddr", fetch_vaddr, tbl[i].target);
      chk("tbl_req", bus.inst_sram_req, tbl[i].e_req);
      tick();
      chk("tbl_valid", bus.if_to_id_valid, tbl[i].e_val);
      if (tbl[i].e_val)
        chk("tbl_zip", bus.if_to_id_zip, mk_zip(NOP, tbl[i].target, 1'b1, tbl[i].e_ec));
    end
    fetch_ex_valid = 1'b0;

    // Streaming: heads in consecutive cycles
    do_reset();
    ao_mode = 1;
    do_mode = 1;
    set_ready(1);
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("stream_valid", bus.if_to_id_valid, 1'b1);
      chk("stream_pc", bus.if_to_id_zip[48:17], RPC + 32'(4 * k));
      tick();
    end

    // ID stall via br_stall: queue fills, request drops, nothing lost on release
    bus.id_allowin = 1'b1;
    bus.br_stall   = 1'b1;
    repeat (10) tick();
    chk("stall_req", bus.inst_sram_req, 1'b0);
    chk("stall_valid", bus.if_to_id_valid, 1'b1);
    ao_mode = 0;
    set_ready(1);
    held = 0;
    for (int n = 0; n < 12; n++) begin
      if (bus.if_to_id_valid) begin
        chk("stall_pc", bus.if_to_id_zip[48:17], RPC + 32'h0c + 32'(4 * held));
        held++;
      end
      tick();
    end
    chk("stall_held", held, DEPTH);

    // Redirect with two outstanding: their responses are dropped
    ao_mode = 1;
    do_mode = 0;
    tick();
    tick();
    tick();
    chk("redir_req_max", bus.inst_sram_req, 1'b0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h1c00_1000;
    tick();
    redirect_valid = 1'b0;
    do_mode        = 1;
    found          = 0;
    for (int n = 0; n < 10; n++) begin
      if (bus.if_to_id_valid) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("redir_found", found, 1'b1);
    if (found) begin
      chk("redir_head_pc", bus.if_to_id_zip[48:17], 32'h1c00_1000);
      chk("redir_head_inst", bus.if_to_id_zip[80:49], inst_of(32'h9c00_1000));
    end

    // Misaligned redirect: no request, ADE marker entry, fetch stays stopped
    set_ready(0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h1c00_0002;
    tick();
    redirect_valid = 1'b0;
    found          = 0;
    for (int n = 0; n < 10; n++) begin
      chk("ade_req", bus.inst_sram_req, 1'b0);
      if (bus.if_to_id_valid) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("ade_found", found, 1'b1);
    chk("ade_zip", bus.if_to_id_zip, mk_zip(NOP, 32'h1c00_0002, 1'b1, ADE));
    repeat (5) tick();
    chk("ade_vaddr", fetch_vaddr, 32'h1c00_0002);
    set_ready(1);
    tick();
    tick();
    chk("ade_drained", bus.if_to_id_valid, 1'b0);
    chk("ade_stopped_req", bus.inst_sram_req, 1'b0);

    // Translator fault with one live request: older instruction first, then TLBR marker
    do_mode         = 0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h1c00_4000;
    tick();
    redirect_valid = 1'b0;
    tick();
    fetch_ex_valid = 1'b1;
    fetch_ex_ecode = TLBR;
    tick();
    tick();
    chk("tlbr_wait", bus.if_to_id_valid, 1'b0);
    do_mode = 1;
    got     = 0;
    for (int n = 0; n < 10 && got < 2; n++) begin
      if (bus.if_to_id_valid) begin
        zips[got] = bus.if_to_id_zip;
        got++;
      end
      tick();
    end
    chk("tlbr_count", got, 2);
    if (got == 2) begin
      chk("tlbr_first", zips[0], mk_zip(inst_of(32'h9c00_4000), 32'h1c00_4000, 1'b0, 6'd0));
      chk("tlbr_second", zips[1], mk_zip(NOP, 32'h1c00_4004, 1'b1, TLBR));
    end
    fetch_ex_valid = 1'b0;

    // Reset with two outstanding: stale responses ignored, restart at RESET_PC
    set_ready(0);
    do_mode         = 0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h1c00_5000;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    chk("rstmid_req_max", bus.inst_sram_req, 1'b0);
    reset   = 1'b1;
    ao_mode = 0;
    tick();
    reset = 1'b0;
    chk("rstmid_valid", bus.if_to_id_valid, 1'b0);
    chk("rstmid_vaddr", fetch_vaddr, RPC);
    do_mode = 1;
    tick();
    chk("rstmid_stale1", bus.if_to_id_valid, 1'b0);
    tick();
    chk("rstmid_stale2", bus.if_to_id_valid, 1'b0);
    ao_mode = 1;
    set_ready(1);
    found = 0;
    for (int n = 0; n < 10; n++) begin
      if (bus.if_to_id_valid) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("rstmid_found", found, 1'b1);
    if (found) chk("rstmid_head_pc", bus.if_to_id_zip[48:17], RPC);

    // Randomized traffic against the reference model
    ao_mode = 2;
    do_mode = 2;
    for (int n = 0; n < 3000; n++) begin
      redirect_valid = ($urandom_range(0, 15) == 0);
      t = ($urandom_range(0, 1) == 1) ? 32'h1c00_0000 : 32'hffff_ff00;
      t = t + 32'($urandom_range(0, 63)) * 32'd4;
      if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
      redirect_target = t;
      fetch_ex_valid  = ($urandom_range(0, 19) == 0);
      fetch_ex_ecode  = 6'($urandom_range(0, 63));
      bus.id_allowin  = ($urandom_range(0, 3) != 0);
      bus.br_stall    = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
